// File: rtl/scsp_out_mixer.sv
// scsp_out_mixer: per-frame stereo mix of slot outputs and DSP effect returns into
// saturating accumulators, master volume and 16-bit clamping at frame close.
module scsp_out_mixer #(
  parameter int ACC_W  = 18,
  parameter int NSLOTS = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ce,
  input  logic        slot_valid,
  input  logic [4:0]  slot,
  input  logic [15:0] sd,
  input  logic [2:0]  disdl,
  input  logic [4:0]  dipan,
  input  logic        ef_valid,
  input  logic [15:0] efreg,
  input  logic [2:0]  efsdl,
  input  logic [4:0]  efpan,
  input  logic [3:0]  mvol,
  input  logic        dac18b,
  input  logic        frame_end,
  output logic [15:0] out_l,
  output logic [15:0] out_r,
  output logic        out_valid,
  output logic        frame_err
);

  localparam int SUM_W = ACC_W + 2;
  localparam logic signed [SUM_W-1:0] ACC_MAX = SUM_W'((1 << (ACC_W - 1)) - 1);
  localparam logic signed [SUM_W-1:0] ACC_MIN = SUM_W'(-(1 << (ACC_W - 1)));
  localparam logic signed [ACC_W-1:0] OUT_MAX = ACC_W'(32767);
  localparam logic signed [ACC_W-1:0] OUT_MIN = ACC_W'(-32768);

  function automatic logic signed [15:0] level(input logic signed [15:0] w,
                                               input logic [2:0] sdl);
    logic [2:0] sh;
    sh = ~sdl;
    if (sdl == 3'd0) return 16'sd0;
    return w >>> sh;
  endfunction

  // Returns {left, right}; the attenuated side is picked by p[4].
  function automatic logic [31:0] pan(input logic signed [15:0] w,
                                      input logic [4:0] p);
    logic signed [15:0] t;
    logic signed [15:0] a;
    t = w >>> p[3:1];
    a = p[0] ? (t - (t >>> 2)) : t;
    return p[4] ? {w, a} : {a, w};
  endfunction

  // Single saturation on the full-precision three-operand sum.
  function automatic logic signed [ACC_W-1:0] sat_add(input logic signed [ACC_W-1:0] acc,
                                                      input logic signed [15:0] a,
                                                      input logic signed [15:0] b);
    logic signed [SUM_W-1:0] s;
    s = SUM_W'(acc) + SUM_W'(a) + SUM_W'(b);
    if (s > ACC_MAX) return ACC_MAX[ACC_W-1:0];
    if (s < ACC_MIN) return ACC_MIN[ACC_W-1:0];
    return s[ACC_W-1:0];
  endfunction

  function automatic logic [15:0] master(input logic signed [ACC_W-1:0] x,
                                         input logic [3:0] mv,
                                         input logic db);
    logic signed [ACC_W-1:0] t1;
    logic signed [ACC_W-1:0] t2;
    logic signed [ACC_W-1:0] t3;
    logic [2:0]              sh;
    sh = ~mv[3:1];
    t1 = db ? (x <<< 2) : x;
    t2 = t1 >>> sh;
    if (mv == 4'd0)  t3 = {ACC_W{1'b0}};
    else if (mv[0])  t3 = t2;
    else             t3 = t2 - (t2 >>> 2);
    if (t3 > OUT_MAX) return 16'h7fff;
    if (t3 < OUT_MIN) return 16'h8000;
    return t3[15:0];
  endfunction

  logic                    slot_take;
  logic                    ef_take;
  logic signed [15:0]      slot_lvl;
  logic signed [15:0]      ef_lvl;
  logic [31:0]             slot_lr;
  logic [31:0]             ef_lr;
  logic signed [ACC_W-1:0] acc_l;
  logic signed [ACC_W-1:0] acc_r;
  logic signed [ACC_W-1:0] acc_l_next;
  logic signed [ACC_W-1:0] acc_r_next;
  logic [5:0]              cnt;
  logic [5:0]              cnt_next;
  logic                    order_err;
  logic                    order_err_next;

  assign slot_take = ce & slot_valid;
  assign ef_take   = ce & ef_valid;

  assign slot_lvl = slot_take ? level($signed(sd), disdl) : 16'sd0;
  assign ef_lvl   = ef_take ? level($signed(efreg), efsdl) : 16'sd0;
  assign slot_lr  = pan(slot_lvl, dipan);
  assign ef_lr    = pan(ef_lvl, efpan);

  assign acc_l_next = sat_add(acc_l, $signed(slot_lr[31:16]), $signed(ef_lr[31:16]));
  assign acc_r_next = sat_add(acc_r, $signed(slot_lr[15:0]), $signed(ef_lr[15:0]));

  assign cnt_next       = (slot_take && cnt != 6'd63) ? cnt + 6'd1 : cnt;
  assign order_err_next = order_err | (slot_take & (slot != cnt[4:0]));

  // Same-cycle contributions belong to the closing frame and are not carried forward.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_l     <= '0;
      acc_r     <= '0;
      cnt       <= '0;
      order_err <= 1'b0;
      out_l     <= '0;
      out_r     <= '0;
      out_valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (ce) begin
        if (frame_end) begin
          out_l     <= master(acc_l_next, mvol, dac18b);
          out_r     <= master(acc_r_next, mvol, dac18b);
          out_valid <= 1'b1;
          frame_err <= (cnt_next != 6'(NSLOTS)) | order_err_next;
          acc_l     <= '0;
          acc_r     <= '0;
          cnt       <= '0;
          order_err <= 1'b0;
        end else begin
          acc_l     <= acc_l_next;
          acc_r     <= acc_r_next;
          cnt       <= cnt_next;
          order_err <= order_err_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_scsp_out_mixer.sv
// Self-checking bench for scsp_out_mixer: directed frames plus randomized frames
// against an integer-arithmetic reference model.
module tb_scsp_out_mixer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ce, slot_valid, ef_valid, dac18b, frame_end;
  logic [4:0]  slot, dipan, efpan;
  logic [15:0] sd, efreg;
  logic [2:0]  disdl, efsdl;
  logic [3:0]  mvol;
  logic [15:0] out_l, out_r;
  logic        out_valid, frame_err;

  int n_cmp = 0;
  int n_bad = 0;

  int m_acc_l, m_acc_r, m_cnt;
  bit m_ord;
  int e_l, e_r;
  bit e_valid, e_err;

  scsp_out_mixer dut (
    .clk(clk), .rst_n(rst_n), .ce(ce),
    .slot_valid(slot_valid), .slot(slot), .sd(sd), .disdl(disdl), .dipan(dipan),
    .ef_valid(ef_valid), .efreg(efreg), .efsdl(efsdl), .efpan(efpan),
    .mvol(mvol), .dac18b(dac18b), .frame_end(frame_end),
    .out_l(out_l), .out_r(out_r), .out_valid(out_valid), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // floor(a / 2^n)
  function automatic int fdiv(input int a, input int n);
    int d;
    d = 1 << n;
    if (a >= 0) return a / d;
    return -((-a + d - 1) / d);
  endfunction

  function automatic int clip(input int v, input int lo, input int hi);
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  task automatic mix(input int w, input int sdl, input int p, output int l, output int r);
    int lv, t, a;
    lv = (sdl == 0) ? 0 : fdiv(w, 7 - sdl);
    t  = fdiv(lv, (p >> 1) & 7);
    a  = (p & 1) ? t - fdiv(t, 2) : t;
    if (p & 16) begin l = lv; r = a; end
    else        begin l = a;  r = lv; end
  endtask

  function automatic int mvol_ref(input int x, input int mv, input bit db);
    int t1, t2, t3;
    t1 = db ? x * 4 : x;
    t1 = ((t1 % 262144) + 262144) % 262144;
    if (t1 >= 131072) t1 -= 262144;
    t2 = fdiv(t1, 7 - (mv >> 1));
    if (mv == 0)     t3 = 0;
    else if (mv & 1) t3 = t2;
    else             t3 = t2 - fdiv(t2, 2);
    return clip(t3, -32768, 32767);
  endfunction

  task automatic model_reset();
    m_acc_l = 0; m_acc_r = 0; m_cnt = 0; m_ord = 0;
    e_l = 0; e_r = 0; e_valid = 0; e_err = 0;
  endtask

  task automatic model_step();
    int sl, sr, el, er;
    e_valid = 0;
    if (!ce) return;
    sl = 0; sr = 0; el = 0; er = 0;
    if (slot_valid) begin
      mix(int'($signed(sd)), int'(disdl), int'(dipan), sl, sr);
      if (int'(slot) != m_cnt % 32) m_ord = 1;
      m_cnt = (m_cnt < 63) ? m_cnt + 1 : 63;
    end
    if (ef_valid) mix(int'($signed(efreg)), int'(efsdl), int'(efpan), el, er);
    m_acc_l = clip(m_acc_l + sl + el, -131072, 131071);
    m_acc_r = clip(m_acc_r + sr + er, -131072, 131071);
    if (frame_end) begin
      e_l = mvol_ref(m_acc_l, int'(mvol), dac18b);
      e_r = mvol_ref(m_acc_r, int'(mvol), dac18b);
      e_err = (m_cnt != 32) || m_ord;
      e_valid = 1;
      m_acc_l = 0; m_acc_r = 0; m_cnt = 0; m_ord = 0;
    end
  endtask

  task automatic check_all();
    chk("out_valid", int'(out_valid), int'(e_valid));
    chk("out_l", int'($signed(out_l)), e_l);
    chk("out_r", int'($signed(out_r)), e_r);
    chk("frame_err", int'(frame_err), int'(e_err));
  endtask

  task automatic idle();
    ce = 1'b1; slot_valid = 1'b0; ef_valid = 1'b0; frame_end = 1'b0;
    slot = '0; sd = '0; disdl = '0; dipan = '0; efreg = '0; efsdl = '0; efpan = '0;
  endtask

  task automatic put_slot(input int s, input logic [15:0] d, input logic [2:0] l, input logic [4:0] p);
    slot_valid = 1'b1; slot = 5'(s); sd = d; disdl = l; dipan = p;
  endtask

  task automatic put_ef(input logic [15:0] d, input logic [2:0] l, input logic [4:0] p);
    ef_valid = 1'b1; efreg = d; efsdl = l; efpan = p;
  endtask

  task automatic close(input logic [3:0] mv, input logic db);
    frame_end = 1'b1; mvol = mv; dac18b = db;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    model_step();
    check_all();
    idle();
  endtask

  task automatic pulse_rst();
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_all();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic one_slot_frame(input logic [4:0] p, input int exp_l, input int exp_r, input string tag);
    put_slot(0, 16'h4000, 3'd7, p);
    cyc();
    close(4'hf, 1'b0);
    cyc();
    chk({tag, "_l"}, int'($signed(out_l)), exp_l);
    chk({tag, "_r"}, int'($signed(out_r)), exp_r);
    chk({tag, "_valid"}, int'(out_valid), 1);
    chk({tag, "_err"}, int'(frame_err), 1);
  endtask

  initial begin
    int target, issued, k;
    bit scramble;
    int seq[32];

    idle();
    mvol = 4'h0; dac18b = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 check_all();
    rst_n = 1'b1;

    // idle after reset
    repeat (100) cyc();
    chk("idle_err", int'(frame_err), 0);

    // single slot frames, centre and panned
    one_slot_frame(5'h00, 16384, 16384, "one");
    cyc();
    chk("one_pulse_end", int'(out_valid), 0);
    one_slot_frame(5'h02, 8192, 16384, "panl");
    one_slot_frame(5'h12, 16384, 8192, "panr");

    // full in-order frame saturating the accumulators
    for (int i = 0; i < 32; i++) begin
      put_slot(i, 16'h7fff, 3'd7, 5'h00);
      cyc();
    end
    close(4'hf, 1'b0);
    cyc();
    chk("sat_l", int'($signed(out_l)), 32767);
    chk("sat_r", int'($signed(out_r)), 32767);
    chk("sat_err", int'(frame_err), 0);

    // contributions in the closing cycle, two master volumes
    put_slot(0, 16'h8000, 3'd6, 5'h00); put_ef(16'hc000, 3'd7, 5'h00); close(4'hf, 1'b0);
    cyc();
    chk("close_f_l", int'($signed(out_l)), -32768);
    chk("close_f_r", int'($signed(out_r)), -32768);
    put_slot(0, 16'h8000, 3'd6, 5'h00); put_ef(16'hc000, 3'd7, 5'h00); close(4'he, 1'b0);
    cyc();
    chk("close_e_l", int'($signed(out_l)), -24576);
    chk("close_e_r", int'($signed(out_r)), -24576);
    put_slot(0, 16'h1000, 3'd7, 5'h00);
    cyc();
    close(4'hf, 1'b1);
    cyc();
    chk("fresh_dac_l", int'($signed(out_l)), 16384);
    chk("fresh_dac_r", int'($signed(out_r)), 16384);

    // empty frame
    close(4'hf, 1'b0);
    cyc();
    chk("empty_l", int'($signed(out_l)), 0);
    chk("empty_err", int'(frame_err), 1);

    // reset mid-frame discards the partial frame
    for (int i = 0; i < 10; i++) begin
      put_slot(i, 16'h3000, 3'd7, 5'h00);
      cyc();
    end
    pulse_rst();
    chk("rst_l", int'($signed(out_l)), 0);
    put_slot(0, 16'h1000, 3'd7, 5'h00);
    cyc();
    close(4'hf, 1'b0);
    cyc();
    chk("rst_frame_l", int'($signed(out_l)), 4096);
    chk("rst_frame_r", int'($signed(out_r)), 4096);
    chk("rst_frame_err", int'(frame_err), 1);

    // right count, wrong order
    for (int i = 0; i < 32; i++) seq[i] = i;
    seq[1] = 2; seq[2] = 1;
    for (int i = 0; i < 32; i++) begin
      put_slot(seq[i], 16'h0100, 3'd7, 5'h00);
      cyc();
    end
    close(4'hf, 1'b0);
    cyc();
    chk("order_err", int'(frame_err), 1);

    // randomized frames
    for (int f = 0; f < 40; f++) begin
      k = $urandom_range(0, 3);
      target = (k == 0) ? $urandom_range(0, 40) : 32;
      scramble = ($urandom_range(0, 4) == 0);
      issued = 0;
      while (issued < target) begin
        ce = ($urandom_range(0, 7) != 0);
        if ($urandom_range(0, 3) != 0) begin
          k = (scramble && $urandom_range(0, 7) == 0) ? $urandom_range(0, 31) : issued % 32;
          put_slot(k, 16'($urandom), 3'($urandom), 5'($urandom));
          if (ce) issued++;
        end
        if ($urandom_range(0, 2) == 0) put_ef(16'($urandom), 3'($urandom), 5'($urandom));
        if (!ce && $urandom_range(0, 5) == 0) close(4'($urandom), 1'($urandom));
        cyc();
      end
      if ($urandom_range(0, 1) == 0) put_slot(issued % 32, 16'($urandom), 3'($urandom), 5'($urandom));
      if ($urandom_range(0, 1) == 0) put_ef(16'($urandom), 3'($urandom), 5'($urandom));
      close(4'($urandom), 1'($urandom));
      cyc();
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
